// File: rtl/io_switch_capture.sv
// io_switch_capture: board-input peripheral for the CPU read mux.
// Synchronises the data switches, sign switch and confirm button, debounces
// the button, and latches the switch value into slot A / slot B on alternate
// qualified presses. Each slot has a valid flag that a CPU read clears.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset
//   sw_raw              raw data switches (async)
//   sw_sign_raw         raw sign switch (async), 1 = negative operand
//   btn_confirm_raw     raw confirm button (async), active-high
//   ioRead / ioRead2    CPU read strobes clearing valid_a / valid_b
//   io_rdata/io_rdata2  captured slot A / slot B values
//   negativeNumber      sign latched at the most recent capture
//   valid_a / valid_b   slot holds unread data
//   slot_sel            slot the next capture writes (0 = A, 1 = B)
module io_switch_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned DATA_W          = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_raw,
  input  logic              sw_sign_raw,
  input  logic              btn_confirm_raw,
  input  logic              ioRead,
  input  logic              ioRead2,
  output logic [DATA_W-1:0] io_rdata,
  output logic [DATA_W-1:0] io_rdata2,
  output logic              negativeNumber,
  output logic              valid_a,
  output logic              valid_b,
  output logic              slot_sel
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_WAIT = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] REL_WAIT   = 2'd3;

  logic [DATA_W-1:0] sw_m, sw_s;
  logic              sign_m, sign_s;
  logic              btn_m, btn_s;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture_c;

  // Two-flop synchronisers for all asynchronous board inputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_m   <= '0;
      sw_s   <= '0;
      sign_m <= 1'b0;
      sign_s <= 1'b0;
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sw_m   <= sw_raw;
      sw_s   <= sw_m;
      sign_m <= sw_sign_raw;
      sign_s <= sign_m;
      btn_m  <= btn_confirm_raw;
      btn_s  <= btn_m;
    end
  end

  // Debounce FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Debounce next-state; capture_c fires on the last stable cycle of a press
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture_c = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          capture_c = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = REL_WAIT;
          cnt_nxt   = '0;
        end
      end
      REL_WAIT: begin
        // A bounce back high during release is still the same press
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Operand slots; a capture set overrides a same-cycle read clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_rdata       <= '0;
      io_rdata2      <= '0;
      negativeNumber <= 1'b0;
      valid_a        <= 1'b0;
      valid_b        <= 1'b0;
      slot_sel       <= 1'b0;
    end else begin
      if (ioRead)  valid_a <= 1'b0;
      if (ioRead2) valid_b <= 1'b0;
      if (capture_c) begin
        if (!slot_sel) begin
          io_rdata <= sw_s;
          valid_a  <= 1'b1;
        end else begin
          io_rdata2 <= sw_s;
          valid_b   <= 1'b1;
        end
        negativeNumber <= sign_s;
        slot_sel       <= ~slot_sel;
      end
    end
  end

endmodule
